// File: rtl/merge_pkg.sv
// Shared definitions for the merge PE: default vector geometry and the
// drain-side state encoding.
package merge_pkg;

  localparam int PSUM_WIDTH_DEF      = 8;
  localparam int TAG_WIDTH_DEF       = 18;
  localparam int PSUM_SPAD_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    LAST = 2'd2
  } drain_state_e;

endpackage

// File: rtl/merge_pe_drain_first_mask.sv
// First-occurrence mask: a valid slot is marked only when no lower valid
// slot carries the same tag. Purely combinational.
module merge_first_mask
  import merge_pkg::*;
#(
  parameter int TAG_WIDTH       = TAG_WIDTH_DEF,
  parameter int PSUM_SPAD_WIDTH = PSUM_SPAD_WIDTH_DEF
) (
  input  logic [TAG_WIDTH*PSUM_SPAD_WIDTH-1:0] tag_i,
  input  logic [PSUM_SPAD_WIDTH-1:0]           valid_i,
  output logic [PSUM_SPAD_WIDTH-1:0]           first_o
);

  logic [PSUM_SPAD_WIDTH-1:0] dup_d;

  // Pairwise tag compare against every lower slot; invalid slots never match.
  always_comb begin
    dup_d   = '0;
    first_o = '0;
    for (int i = 0; i < PSUM_SPAD_WIDTH; i++) begin
      for (int k = 0; k < PSUM_SPAD_WIDTH; k++) begin
        if ((k < i) && valid_i[k] &&
            (tag_i[k*TAG_WIDTH +: TAG_WIDTH] == tag_i[i*TAG_WIDTH +: TAG_WIDTH])) begin
          dup_d[i] = 1'b1;
        end else begin
          dup_d[i] = dup_d[i];
        end
      end
      first_o[i] = valid_i[i] & ~dup_d[i];
    end
  end

endmodule

// File: rtl/merge_pe_drain.sv
// Reader side of the merge PE: captures one merged vector and streams its
// unique (tag, psum) pairs, lowest slot first, over valid/ready.
module merge_pe_drain
  import merge_pkg::*;
#(
  parameter int  PSUM_WIDTH      = PSUM_WIDTH_DEF,
  parameter int  TAG_WIDTH       = TAG_WIDTH_DEF,
  parameter int  PSUM_SPAD_WIDTH = PSUM_SPAD_WIDTH_DEF,
  localparam int IDX_WIDTH       = $clog2(PSUM_SPAD_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [PSUM_WIDTH*PSUM_SPAD_WIDTH-1:0] psum_in,
  input  logic [TAG_WIDTH*PSUM_SPAD_WIDTH-1:0]  tag_in,
  input  logic [PSUM_SPAD_WIDTH-1:0]            slot_valid_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [PSUM_WIDTH-1:0]                 out_psum,
  output logic [TAG_WIDTH-1:0]                  out_tag,
  output logic [IDX_WIDTH-1:0]                  out_idx,
  output logic                                  out_last,
  output logic                                  done,
  output logic [IDX_WIDTH:0]                    uniq_count
);

  drain_state_e                          state_q;
  logic                                  in_ready_q;
  logic                                  out_valid_q;
  logic                                  out_last_q;
  logic                                  done_q;
  logic [PSUM_WIDTH-1:0]                 out_psum_q;
  logic [TAG_WIDTH-1:0]                  out_tag_q;
  logic [IDX_WIDTH-1:0]                  out_idx_q;
  logic [IDX_WIDTH:0]                    uniq_count_q;
  logic [PSUM_SPAD_WIDTH-1:0]            pending_q;
  logic [PSUM_WIDTH*PSUM_SPAD_WIDTH-1:0] psum_q;
  logic [TAG_WIDTH*PSUM_SPAD_WIDTH-1:0]  tag_q;

  logic [PSUM_SPAD_WIDTH-1:0]            first_mask_d;
  logic [IDX_WIDTH-1:0]                  pick_idx_d;
  logic                                  single_d;
  logic                                  load_d;

  merge_first_mask #(
    .TAG_WIDTH       (TAG_WIDTH),
    .PSUM_SPAD_WIDTH (PSUM_SPAD_WIDTH)
  ) u_first_mask (
    .tag_i   (tag_in),
    .valid_i (slot_valid_in),
    .first_o (first_mask_d)
  );

  // Lowest set pending bit selects the next slot; a load may happen whenever
  // the output register is empty or being consumed this cycle.
  always_comb begin
    pick_idx_d = '0;
    for (int i = PSUM_SPAD_WIDTH - 1; i >= 0; i--) begin
      pick_idx_d = pending_q[i] ? IDX_WIDTH'(i) : pick_idx_d;
    end
    single_d = ((pending_q & (pending_q - PSUM_SPAD_WIDTH'(1))) == '0);
    load_d   = (!out_valid_q || out_ready) && (pending_q != '0);
  end

  // Drain FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
      out_psum_q   <= '0;
      out_tag_q    <= '0;
      out_idx_q    <= '0;
      uniq_count_q <= '0;
      pending_q    <= '0;
      psum_q       <= '0;
      tag_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            psum_q       <= psum_in;
            tag_q        <= tag_in;
            pending_q    <= first_mask_d;
            uniq_count_q <= '0;
            in_ready_q   <= 1'b0;
            state_q      <= EMIT;
          end
        end
        EMIT: begin
          if (pending_q == '0) begin
            // Nothing unique in this vector: finish without emitting.
            done_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else if (load_d) begin
            out_psum_q            <= psum_q[pick_idx_d*PSUM_WIDTH +: PSUM_WIDTH];
            out_tag_q             <= tag_q[pick_idx_d*TAG_WIDTH +: TAG_WIDTH];
            out_idx_q             <= pick_idx_d;
            pending_q[pick_idx_d] <= 1'b0;
            out_valid_q           <= 1'b1;
            out_last_q            <= single_d;
            uniq_count_q          <= uniq_count_q + (IDX_WIDTH+1)'(1);
            if (single_d) begin
              state_q <= LAST;
            end
          end
        end
        LAST: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          pending_q   <= '0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign done       = done_q;
  assign out_psum   = out_psum_q;
  assign out_tag    = out_tag_q;
  assign out_idx    = out_idx_q;
  assign uniq_count = uniq_count_q;

endmodule

// File: doc/merge_pe_drain.md
Name: merge_pe_drain

Overview:
- Reader side of the merge PE.
- Accepts one merged psum vector plus its tag vector and a slot-valid mask. Computes which slots hold the first occurrence of each tag; only those slots carry the complete merged sum.
- Streams the unique (tag, psum) pairs, one per cycle, over a valid/ready interface toward the output feature buffer.
- Sits between the combinational merge stage and the output-buffer write port.

Parameters:
- PSUM_WIDTH, 8, bit width of one psum.
- TAG_WIDTH, 18, bit width of one destination-node tag.
- PSUM_SPAD_WIDTH, 16, number of psum/tag slots per vector.
- IDX_WIDTH, $clog2(PSUM_SPAD_WIDTH), slot-index width (derived, not overridden).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  merged vector present
- in_ready  output  1  drain can accept a vector
- psum_in  input  PSUM_WIDTH*PSUM_SPAD_WIDTH  merged psums; slot i at bits [i*PSUM_WIDTH +: PSUM_WIDTH]
- tag_in  input  TAG_WIDTH*PSUM_SPAD_WIDTH  tags, same packing
- slot_valid_in  input  PSUM_SPAD_WIDTH  bit i = slot i holds real data
- out_valid  output  1  output pair valid
- out_ready  input  1  downstream accepts pair
- out_psum  output  PSUM_WIDTH  merged sum
- out_tag  output  TAG_WIDTH  tag of that sum
- out_idx  output  IDX_WIDTH  source slot index
- out_last  output  1  final unique pair of this vector
- done  output  1  one-cycle pulse when a vector is fully drained
- uniq_count  output  IDX_WIDTH+1  unique pairs emitted for the current/last vector

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high. Reset forces:
  - state = IDLE, in_ready = 1, out_valid = 0, out_last = 0, done = 0;
  - out_psum, out_tag, out_idx and uniq_count = 0;
  - pending mask and captured vectors cleared.
- Reset mid-drain drops the vector; no further output until a new accept.
- First mask (combinational, on inputs):
  - first[i] = slot_valid_in[i] & ~OR over k<i of (slot_valid_in[k] & tag[k]==tag[i]).
  - Invalid slots never match.
- States IDLE, EMIT, LAST.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready (cycle t), register psum_in and tag_in, set pending = first mask, clear uniq_count, go to EMIT.
- EMIT:
  - in_ready = 0.
  - When out_valid==0 or out_ready==1, and pending != 0:
    - load output register from the lowest set bit p of pending: out_psum = psum[p], out_tag = tag[p], out_idx = p;
    - clear pending[p], set out_valid = 1, increment uniq_count;
    - out_last = 1 iff pending had exactly one bit set; in that case go to LAST.
  - First out_valid is in cycle t+2. Throughput is one pair/cycle while out_ready is held high.
  - out_* are stable while out_valid & ~out_ready.
- EMIT with pending == 0 on entry (empty mask):
  - no out_valid;
  - done pulses the next cycle;
  - return to IDLE.
- LAST:
  - Hold the output until out_valid & out_ready.
  - On that handshake: out_valid = 0, out_last = 0, done = 1 for one cycle, go to IDLE. in_ready is high the cycle after.
- Backpressure: a new pair loads on the same edge the previous pair handshakes (no bubble).
- A new vector is never accepted while draining. in_valid held high in EMIT/LAST is ignored until IDLE.
- Upstream guarantees invalid slots carry psum 0. The drain does not modify psum values; there is no arithmetic.

Decomposition:
- Shared package merge_pkg:
  - state encoding (IDLE=2'd0, EMIT=2'd1, LAST=2'd2);
  - the default widths PSUM_WIDTH/TAG_WIDTH/PSUM_SPAD_WIDTH as localparams shared with the merge PE.
- One natural sub-module, merge_first_mask: purely combinational tag-compare / first-occurrence mask generator, parameterised like the top.
- Priority encoder stays inline.

Test Plan:
- Tags all distinct {0..15}, psums 1..16, mask 0xFFFF, out_ready=1 → 16 pairs idx 0..15 on consecutive cycles from t+2; out_last on idx 15; done pulse; uniq_count=16.
- Tags slot0=5, slot3=5, slot7=9, rest masked off (mask 0x0089), merged psums 30/10/4 → exactly two pairs: (5,30,idx0), then (9,4,idx7, last). Slot 3 suppressed.
- Mask 0x0000 with in_valid → no out_valid, done one cycle later, in_ready back high, uniq_count=0.
- out_ready low for 3 cycles during pair idx 2 → out_* stable for those cycles; idx 3 appears the cycle after out_ready rises; no pair lost or duplicated.
- Invalid slot 4 has same tag as valid slot 9 (mask has bit 9, not bit 4) → slot 9 emitted as first occurrence.
- reset asserted mid-EMIT after 2 pairs → next cycle out_valid=0, in_ready=1, uniq_count=0; new vector drains correctly.
